fft_radix4_iter: RTL and testbench
==================================

# fft_radix4_iter

Parametrised, iterative radix-4 decimation-in-time FFT. It supersedes the fixed two-stage 16-point array in the audio-visualizer datapath. It supports N = 4^S points (16, 64, 256), optional per-stage scaling and configurable twiddle precision. A single butterfly is time-multiplexed over an in-place register buffer, one butterfly per cycle. It sits between the sample-window buffer and the magnitude/bin-mapping logic.

## Interface
- WIDTH, 12: signed input sample width.
- N, 16: transform length; must be a power of 4, at least 16. S = log4(N) stages.
- COEF_W, 14: signed twiddle width. Twiddles use Q2.(COEF_W-2).
- SCALE, 0: selects per-stage scaling.
  - 0: none.
  - 1: arithmetic shift right by 2 after every stage.
- Derived: IW = WIDTH+2*S+2 (internal width). OUT_W = SCALE ? WIDTH+2 : WIDTH+2*S+1.
- clk, in, 1: clock. All logic is on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: request a transform. Sampled only in IDLE.
- time_samples, in, [0:N-1] x WIDTH: signed real samples. Must be stable on the accepting edge only.
- busy, out, 1: high while a transform is in progress.
- done, out, 1: one-cycle pulse; freq outputs are updated in the same cycle.
- freq_real, out, [0:N-1] x OUT_W: signed real part of X[k].
- freq_imag, out, [0:N-1] x OUT_W: signed imaginary part of X[k].

## Operation
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start.
  - RUN -> DONE after the final butterfly.
  - DONE -> IDLE unconditionally.
- Accept edge (IDLE with start=1):
  - Each sample is sign-extended to IW and written to the buffer at its base-4 digit-reversed index.
  - Buffer imaginary parts are set to 0.
  - Stage counter s=0, butterfly counter b=0.
- RUN, per cycle, for butterfly b of stage s:
  - L = 4^s. g = b / L, k = b mod L.
  - i0 = 4Lg+k, i1 = i0+L, i2 = i0+2L, i3 = i0+3L.
  - Twiddle exponents: e_m = m·k·N/(4L) for m = 1..3, with W^e = cos(2πe/N) − j·sin(2πe/N).
  - Twiddle ROM: elaboration-time constants, rounded to nearest, scaled by 2^(COEF_W-2).
  - Complex multiply: full-precision product, add 2^(COEF_W-3), arithmetic shift right by COEF_W-2, truncate to IW. The x0 term (m=0) is not multiplied.
- Butterfly outputs, written in place on the same edge:
  - y0 = a+b+c+d
  - y1 = a−jb−c+jd
  - y2 = a−b+c−d
  - y3 = a+jb−c−jd
  - With SCALE=1, every y is arithmetic-shifted right by 2 before the write.
- Counters:
  - b wraps at N/4−1, then s increments.
  - After s=S−1 and b=N/4−1, the next state is DONE.
- DONE edge:
  - freq_real[k] and freq_imag[k] take buffer[k] (natural order), truncated to the low OUT_W bits.
  - done is asserted for one cycle.
- Overflow: IW cannot overflow for full-scale input. Output truncation is lossless for full-scale input when SCALE=0.
- start while busy is ignored; no queuing.
- time_samples changes after the accept edge have no effect.

## Timing
- Reset values:
  - busy=0, done=0, all freq outputs 0, state IDLE.
  - Buffer contents are don't-care.
- rst during RUN or DONE:
  - The next state is IDLE with all outputs 0.
  - No done pulse is produced.
  - rst overrides a simultaneous start.
- Latency: start accepted at edge t; done high in the cycle after edge t+S·N/4+1. N=16 gives 9 edges; N=64 gives 49 edges.
- busy timing: high from edge t through edge t+S·N/4+1 (RUN and DONE). It is low in the cycle done is high.
- Back-to-back operation: start may be high in the done cycle. It is accepted, and the new results replace the old at the next done.
- Throughput: one transform per S·N/4+2 cycles.
- Outputs hold their values between done pulses.

## Test plan
- Impulse, N=16, SCALE=0: x[0]=1000, all others 0 → every bin real=1000, imag=0. done exactly 9 edges after the accept edge.
- DC, N=16:
  - SCALE=0, all x=100 → X[0] real=1600, all other bins |re|,|im| ≤ 1.
  - SCALE=1, same input → X[0]=100.
- Tone, N=64, SCALE=0: x[n]=round(1024·cos(2πn/64)) → X[1] and X[63] real = 32768±8, imag within ±8. All other bins within ±8.
- Full-scale alternating, N=16: x[n]=(−1)^n·2047 → X[8] real=32752, others 0. No wrap on any output.
- Protocol:
  - start pulsed 3 cycles into RUN → ignored, single done pulse.
  - start held high → back-to-back done pulses every 10 cycles (N=16).
- Reset mid-run: rst asserted at RUN cycle 4 → busy=0, outputs 0 on the next cycle, no done. A subsequent start produces correct results.

Source files
------------

// File: rtl/fft_radix4_iter_if.sv
// fft_radix4_iter_if: start/sample handshake and spectrum result bus for the radix-4 FFT
interface fft_radix4_iter_if #(
  parameter int WIDTH = 12,
  parameter int N = 16,
  parameter int SCALE = 0
);
  localparam int S = $clog2(N) / 2;
  localparam int OUT_W = SCALE != 0 ? WIDTH + 2 : WIDTH + 2 * S + 1;
  logic start;
  logic busy;
  logic done;
  logic signed [WIDTH-1:0] time_samples [N];
  logic signed [OUT_W-1:0] freq_real [N];
  logic signed [OUT_W-1:0] freq_imag [N];
  modport master (output start, time_samples, input busy, done, freq_real, freq_imag);
  modport slave (input start, time_samples, output busy, done, freq_real, freq_imag);
endinterface

// File: rtl/fft_radix4_iter.sv
// fft_radix4_iter: iterative in-place radix-4 DIT FFT, one butterfly per cycle
module fft_radix4_iter #(
  parameter int WIDTH = 12,
  parameter int N = 16,
  parameter int COEF_W = 14,
  parameter int SCALE = 0
) (
  input logic clk,
  input logic rst,
  fft_radix4_iter_if.slave bus
);
  localparam int S = $clog2(N) / 2;
  localparam int AW = $clog2(N);
  localparam int IW = WIDTH + 2 * S + 2;
  localparam int OUT_W = SCALE != 0 ? WIDTH + 2 : WIDTH + 2 * S + 1;
  localparam int PW = IW + COEF_W + 1;
  localparam int FB = COEF_W - 2;
  localparam logic signed [PW-1:0] RND = PW'(1) << (FB - 1);
  localparam real TWO_PI = 6.283185307179586;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [AW-1:0] s_q, b_q, msk, k, e1;
  logic [AW-1:0] idx [4];
  logic [AW-1:0] ex [4];
  logic signed [IW-1:0] mem_re [N];
  logic signed [IW-1:0] mem_im [N];
  logic signed [IW-1:0] t_re [4], t_im [4], u_re [4], u_im [4], y_re [4], y_im [4];
  logic signed [PW-1:0] p_re [4], p_im [4];
  logic signed [COEF_W-1:0] cos_rom [N];
  logic signed [COEF_W-1:0] nsin_rom [N];
  logic last;
  function automatic logic [AW-1:0] rev4(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    for (int d = 0; d < S; d++) r[2*d +: 2] = v[AW-2-2*d +: 2];
    return r;
  endfunction
  // W^e = cos - j*sin, rounded to nearest in Q2.FB
  for (genvar i = 0; i < N; i++) begin : g_rom
    localparam real C = $cos(TWO_PI * i / N) * (1 << FB);
    localparam real D = -$sin(TWO_PI * i / N) * (1 << FB);
    assign cos_rom[i] = COEF_W'($rtoi(C < 0.0 ? C - 0.5 : C + 0.5));
    assign nsin_rom[i] = COEF_W'($rtoi(D < 0.0 ? D - 0.5 : D + 0.5));
  end
  always_comb begin
    msk = AW'((1 << (2 * s_q)) - 1);
    k = b_q & msk;
    idx[0] = ((b_q & ~msk) << 2) | k;
    for (int m = 1; m < 4; m++) idx[m] = idx[0] + AW'(m << (2 * s_q));
    e1 = k * AW'((N / 4) >> (2 * s_q));
    ex[0] = '0;
    ex[1] = e1;
    ex[2] = e1 << 1;
    ex[3] = e1 + (e1 << 1);
    for (int m = 0; m < 4; m++) begin
      p_re[m] = PW'(mem_re[idx[m]]) * PW'(cos_rom[ex[m]]) - PW'(mem_im[idx[m]]) * PW'(nsin_rom[ex[m]]);
      p_im[m] = PW'(mem_re[idx[m]]) * PW'(nsin_rom[ex[m]]) + PW'(mem_im[idx[m]]) * PW'(cos_rom[ex[m]]);
      t_re[m] = m == 0 ? mem_re[idx[m]] : IW'((p_re[m] + RND) >>> FB);
      t_im[m] = m == 0 ? mem_im[idx[m]] : IW'((p_im[m] + RND) >>> FB);
    end
    u_re[0] = t_re[0] + t_re[1] + t_re[2] + t_re[3];
    u_im[0] = t_im[0] + t_im[1] + t_im[2] + t_im[3];
    u_re[1] = t_re[0] + t_im[1] - t_re[2] - t_im[3];
    u_im[1] = t_im[0] - t_re[1] - t_im[2] + t_re[3];
    u_re[2] = t_re[0] - t_re[1] + t_re[2] - t_re[3];
    u_im[2] = t_im[0] - t_im[1] + t_im[2] - t_im[3];
    u_re[3] = t_re[0] - t_im[1] - t_re[2] + t_im[3];
    u_im[3] = t_im[0] + t_re[1] - t_im[2] - t_re[3];
    for (int m = 0; m < 4; m++) begin
      y_re[m] = SCALE != 0 ? u_re[m] >>> 2 : u_re[m];
      y_im[m] = SCALE != 0 ? u_im[m] >>> 2 : u_im[m];
    end
  end
  assign last = s_q == AW'(S - 1) && b_q == AW'(N / 4 - 1);
  assign bus.busy = state != IDLE;
  always_comb begin
    state_n = state == IDLE ? (bus.start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= '0;
      b_q <= '0;
      bus.done <= 1'b0;
      for (int n = 0; n < N; n++) begin
        bus.freq_real[n] <= '0;
        bus.freq_imag[n] <= '0;
      end
    end else begin
      bus.done <= state == DONE;
      b_q <= state == RUN && b_q != AW'(N / 4 - 1) ? b_q + 1'b1 : '0;
      s_q <= state != RUN ? '0 : b_q == AW'(N / 4 - 1) ? s_q + 1'b1 : s_q;
      if (state == DONE)
        for (int n = 0; n < N; n++) begin
          bus.freq_real[n] <= OUT_W'(mem_re[n]);
          bus.freq_imag[n] <= OUT_W'(mem_im[n]);
        end
    end
  end
  // samples land digit-reversed so the in-place passes leave bins in natural order
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) begin
      for (int n = 0; n < N; n++) begin
        mem_re[rev4(AW'(n))] <= IW'(bus.time_samples[n]);
        mem_im[n] <= '0;
      end
    end else if (state == RUN) begin
      for (int m = 0; m < 4; m++) begin
        mem_re[idx[m]] <= y_re[m];
        mem_im[idx[m]] <= y_im[m];
      end
    end
  end
endmodule

// File: tb/tb_fft_radix4_iter.sv
// tb_fft_radix4_iter: directed checks of the radix-4 FFT at N=16 (scaled and unscaled) and N=64
module tb_fft_radix4_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  fft_radix4_iter_if #(.WIDTH(12), .N(16), .SCALE(0)) ia ();
  fft_radix4_iter_if #(.WIDTH(12), .N(16), .SCALE(1)) ib ();
  fft_radix4_iter_if #(.WIDTH(12), .N(64), .SCALE(0)) ic ();
  fft_radix4_iter #(.WIDTH(12), .N(16), .COEF_W(14), .SCALE(0)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  fft_radix4_iter #(.WIDTH(12), .N(16), .COEF_W(14), .SCALE(1)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  fft_radix4_iter #(.WIDTH(12), .N(64), .COEF_W(14), .SCALE(0)) dut_c (.clk(clk), .rst(rst), .bus(ic));

  task automatic run(input int which, output int lat);
    @(negedge clk);
    ia.start = which == 0;
    ib.start = which == 1;
    ic.start = which == 2;
    @(posedge clk); #1;
    ia.start = 1'b0;
    ib.start = 1'b0;
    ic.start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if ((which == 0 && ia.done) || (which == 1 && ib.done) || (which == 2 && ic.done)) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic load_impulse(input int v);
    for (int n = 0; n < 16; n++) ia.time_samples[n] = n == 0 ? 12'(v) : 12'sd0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    ia.start = 1'b0;
    ib.start = 1'b0;
    ic.start = 1'b0;
    for (int n = 0; n < 16; n++) begin
      ia.time_samples[n] = '0;
      ib.time_samples[n] = '0;
    end
    for (int n = 0; n < 64; n++) ic.time_samples[n] = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (ia.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy_a got %b want 0", ia.busy); end
    n_cmp++; if (ia.done !== 1'b0) begin n_bad++; $display("FAIL reset_done_a got %b want 0", ia.done); end
    n_cmp++; if (ic.busy !== 1'b0 || ic.done !== 1'b0) begin n_bad++; $display("FAIL reset_c got busy=%b done=%b want 0/0", ic.busy, ic.done); end
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if (int'(ia.freq_real[k]) !== 0 || int'(ia.freq_imag[k]) !== 0) begin
        n_bad++; $display("FAIL reset_freq[%0d] got %0d,%0d want 0,0", k, ia.freq_real[k], ia.freq_imag[k]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_impulse;
    int lat;
    load_impulse(1000);
    run(0, lat);
    n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL impulse_latency got %0d want 9", lat); end
    n_cmp++; if (ia.busy !== 1'b0) begin n_bad++; $display("FAIL busy_in_done got %b want 0", ia.busy); end
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if (int'(ia.freq_real[k]) !== 1000 || int'(ia.freq_imag[k]) !== 0) begin
        n_bad++; $display("FAIL impulse_bin[%0d] got %0d,%0d want 1000,0", k, ia.freq_real[k], ia.freq_imag[k]);
      end
    end
  endtask

  task automatic test_dc;
    int lat, re, im;
    for (int n = 0; n < 16; n++) begin
      ia.time_samples[n] = 12'sd100;
      ib.time_samples[n] = 12'sd100;
    end
    run(0, lat);
    n_cmp++; if (int'(ia.freq_real[0]) !== 1600 || int'(ia.freq_imag[0]) !== 0) begin
      n_bad++; $display("FAIL dc_x0 got %0d,%0d want 1600,0", ia.freq_real[0], ia.freq_imag[0]);
    end
    for (int k = 1; k < 16; k++) begin
      re = ia.freq_real[k];
      im = ia.freq_imag[k];
      n_cmp++;
      if (re > 1 || re < -1 || im > 1 || im < -1) begin
        n_bad++; $display("FAIL dc_bin[%0d] got %0d,%0d want within 1 of 0", k, re, im);
      end
    end
    run(1, lat);
    n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL dc_scaled_latency got %0d want 9", lat); end
    n_cmp++; if (int'(ib.freq_real[0]) !== 100 || int'(ib.freq_imag[0]) !== 0) begin
      n_bad++; $display("FAIL dc_scaled_x0 got %0d,%0d want 100,0", ib.freq_real[0], ib.freq_imag[0]);
    end
    for (int k = 1; k < 16; k++) begin
      re = ib.freq_real[k];
      im = ib.freq_imag[k];
      n_cmp++;
      if (re > 1 || re < -1 || im > 1 || im < -1) begin
        n_bad++; $display("FAIL dc_scaled_bin[%0d] got %0d,%0d want within 1 of 0", k, re, im);
      end
    end
  endtask

  task automatic test_tone;
    int lat, re, im, ex;
    for (int n = 0; n < 64; n++) begin
      real x;
      x = 1024.0 * $cos(6.283185307179586 * n / 64);
      ic.time_samples[n] = 12'($rtoi(x < 0.0 ? x - 0.5 : x + 0.5));
    end
    run(2, lat);
    n_cmp++; if (lat !== 49) begin n_bad++; $display("FAIL tone_latency got %0d want 49", lat); end
    for (int k = 0; k < 64; k++) begin
      ex = (k == 1 || k == 63) ? 32768 : 0;
      re = ic.freq_real[k];
      im = ic.freq_imag[k];
      n_cmp++;
      if (re - ex > 8 || ex - re > 8 || im > 8 || im < -8) begin
        n_bad++; $display("FAIL tone_bin[%0d] got %0d,%0d want %0d,0 within 8", k, re, im, ex);
      end
    end
  endtask

  task automatic test_fullscale;
    int lat;
    for (int n = 0; n < 16; n++) ia.time_samples[n] = n % 2 == 0 ? 12'sd2047 : -12'sd2047;
    run(0, lat);
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if (int'(ia.freq_real[k]) !== (k == 8 ? 32752 : 0) || int'(ia.freq_imag[k]) !== 0) begin
        n_bad++; $display("FAIL fullscale_bin[%0d] got %0d,%0d want %0d,0", k, ia.freq_real[k], ia.freq_imag[k], k == 8 ? 32752 : 0);
      end
    end
  endtask

  task automatic test_start_ignored;
    int dones, first;
    dones = 0;
    first = -1;
    load_impulse(500);
    @(negedge clk);
    ia.start = 1'b1;
    @(posedge clk); #1;
    ia.start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 4) ia.start = 1'b1;
      if (c == 5) ia.start = 1'b0;
      @(posedge clk); #1;
      if (c == 3) begin
        n_cmp++; if (ia.busy !== 1'b1) begin n_bad++; $display("FAIL busy_in_run got %b want 1", ia.busy); end
      end
      if (ia.done) begin
        dones++;
        if (first < 0) first = c;
      end
    end
    n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL ignored_start_dones got %0d want 1", dones); end
    n_cmp++; if (first !== 9) begin n_bad++; $display("FAIL ignored_start_latency got %0d want 9", first); end
    n_cmp++; if (int'(ia.freq_real[5]) !== 500) begin n_bad++; $display("FAIL ignored_start_bin5 got %0d want 500", ia.freq_real[5]); end
  endtask

  task automatic test_back_to_back;
    int cnt, v1, v2;
    int t [3];
    cnt = 0;
    v1 = -1;
    v2 = -1;
    t = '{-1, -1, -1};
    load_impulse(300);
    @(negedge clk);
    ia.start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 29; c++) begin
      @(posedge clk); #1;
      if (c == 5) load_impulse(600);
      if (ia.done && cnt < 3) begin
        t[cnt] = c;
        cnt++;
      end
      if (c == 9) v1 = ia.freq_real[2];
      if (c == 19) v2 = ia.freq_real[2];
    end
    @(negedge clk);
    ia.start = 1'b0;
    n_cmp++; if (t[0] !== 9) begin n_bad++; $display("FAIL b2b_done0 got %0d want 9", t[0]); end
    n_cmp++; if (t[1] !== 19) begin n_bad++; $display("FAIL b2b_done1 got %0d want 19", t[1]); end
    n_cmp++; if (t[2] !== 29) begin n_bad++; $display("FAIL b2b_done2 got %0d want 29", t[2]); end
    n_cmp++; if (v1 !== 300) begin n_bad++; $display("FAIL b2b_first_result got %0d want 300", v1); end
    n_cmp++; if (v2 !== 600) begin n_bad++; $display("FAIL b2b_second_result got %0d want 600", v2); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (ia.busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_after got %b want 0", ia.busy); end
  endtask

  task automatic test_reset_mid_run;
    int lat, dones;
    dones = 0;
    load_impulse(700);
    @(negedge clk);
    ia.start = 1'b1;
    @(posedge clk); #1;
    ia.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    ia.start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ia.start = 1'b0;
    n_cmp++; if (ia.busy !== 1'b0 || ia.done !== 1'b0) begin n_bad++; $display("FAIL midrst_busy_done got %b/%b want 0/0", ia.busy, ia.done); end
    for (int k = 0; k < 16; k += 5) begin
      n_cmp++;
      if (int'(ia.freq_real[k]) !== 0) begin n_bad++; $display("FAIL midrst_freq[%0d] got %0d want 0", k, ia.freq_real[k]); end
    end
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (ia.done || ia.busy) dones++;
    end
    n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL midrst_activity got %0d cycles want 0", dones); end
    run(0, lat);
    n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL midrst_rerun_latency got %0d want 9", lat); end
    for (int k = 0; k < 16; k += 3) begin
      n_cmp++;
      if (int'(ia.freq_real[k]) !== 700 || int'(ia.freq_imag[k]) !== 0) begin
        n_bad++; $display("FAIL midrst_rerun_bin[%0d] got %0d,%0d want 700,0", k, ia.freq_real[k], ia.freq_imag[k]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_impulse;
    test_dc;
    test_tone;
    test_fullscale;
    test_start_ignored;
    test_back_to_back;
    test_reset_mid_run;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
